// File: rtl/byte_lane_memory_unit.sv
// Byte-lane memory unit: LANES byte-wide block RAM banks behind a valid/ready
// request/response port, supporting big-endian sub-word accesses at any alignment.
module byte_lane_memory_unit #(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [8*LANES-1:0]    req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [8*LANES-1:0]    resp_rdata,
    output logic                  resp_error
);
    localparam int LB   = $clog2(LANES);
    localparam int WA   = ADDR_WIDTH - LB;
    localparam int ROWS = 1 << WA;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    state_t state_q, state_d;

    logic                  accept;
    logic                  size_ok;
    logic [LB:0]           n_req;
    logic [LB-1:0]         n_m1;
    logic [LB-1:0]         col0;
    logic [WA-1:0]         row0;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  wrap;
    logic                  write_fire;
    logic                  read_fire;

    logic [LB-1:0]         n_m1_q;
    logic [LB-1:0]         col0_q;
    logic                  signed_q;
    logic                  size_ok_q;
    logic                  resp_error_q;
    logic [8*LANES-1:0]    resp_rdata_q;

    logic [8*LANES-1:0]    bank_rd;
    logic [8*LANES-1:0]    load_data;
    logic [LB-1:0]         a_col;
    logic                  load_sign;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign size_ok    = (int'(req_size) <= LB);
    assign n_req      = (LB+1)'(1) << req_size;
    assign n_m1       = LB'(n_req - (LB+1)'(1));
    assign col0       = req_addr[LB-1:0];
    assign row0       = req_addr[ADDR_WIDTH-1:LB];
    // The carry out of the last byte address flags an access past the top.
    assign end_addr   = {1'b0, req_addr} + (ADDR_WIDTH+1)'(n_req) - (ADDR_WIDTH+1)'(1);
    assign wrap       = end_addr[ADDR_WIDTH];
    assign write_fire = accept && req_store && size_ok && !wrap;
    assign read_fire  = accept && !req_store;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            localparam logic [LB-1:0] COL = LB'(LANES - 1 - gi);
            logic [LB-1:0] p;
            logic [LB-1:0] sh;
            logic          touched;
            logic [WA-1:0] row;
            logic          we;
            logic [7:0]    wbyte;
            logic [7:0]    rd_q;

            // p is the logical byte landing in this bank; lanes left of the
            // start column belong to the following row.
            assign p       = COL - col0;
            assign touched = ({1'b0, p} < n_req);
            assign row     = row0 + WA'(COL < col0);
            assign sh      = n_m1 - p;
            assign wbyte   = 8'(req_wdata >> {sh, 3'b000});
            assign we      = write_fire && touched;
            assign bank_rd[8*gi +: 8] = rd_q;

            if (INIT_ZERO != 0) begin : g_init
                logic [7:0] mem_q [ROWS] = '{default: 8'h00};
                always_ff @(posedge CLOCK_50) begin
                    if (we) begin
                        mem_q[row] <= wbyte;
                    end
                    if (read_fire) begin
                        rd_q <= mem_q[row];
                    end
                end
            end else begin : g_noinit
                logic [7:0] mem_q [ROWS];
                always_ff @(posedge CLOCK_50) begin
                    if (we) begin
                        mem_q[row] <= wbyte;
                    end
                    if (read_fire) begin
                        rd_q <= mem_q[row];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        load_data = '0;
        a_col     = '0;
        load_sign = 1'b0;
        for (int p = 0; p < LANES; p++) begin
            if (p <= int'(n_m1_q)) begin
                a_col = col0_q + LB'(p);
                load_data[8*(int'(n_m1_q) - p) +: 8] = bank_rd[8*(LANES-1-int'(a_col)) +: 8];
            end
        end
        load_sign = signed_q && load_data[{n_m1_q, 3'b111}];
        for (int k = 0; k < LANES; k++) begin
            if (k > int'(n_m1_q)) begin
                load_data[8*k +: 8] = {8{load_sign}};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_store ? RESP : READ;
            READ:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else if (accept) begin
            n_m1_q       <= n_m1;
            col0_q       <= col0;
            signed_q     <= req_signed;
            size_ok_q    <= size_ok;
            resp_error_q <= !size_ok || wrap;
            resp_rdata_q <= '0;
        end else if (state_q == READ) begin
            resp_rdata_q <= size_ok_q ? load_data : '0;
        end
    end
endmodule

// File: tb/tb_byte_lane_memory_unit.sv
// Directed and randomized bench for byte_lane_memory_unit against a flat
// byte-array reference model of the memory.
module tb_byte_lane_memory_unit;
    localparam int LANES     = 4;
    localparam int AW        = 18;
    localparam int DW        = 8 * LANES;
    localparam int MEM_BYTES = 1 << AW;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          req_valid  = 1'b0;
    logic          req_store  = 1'b0;
    logic [1:0]    req_size   = 2'd0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr   = '0;
    logic [DW-1:0] req_wdata  = '0;
    logic          resp_ready = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_error;
    logic [DW-1:0] resp_rdata;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    logic [7:0] mem_m [MEM_BYTES];

    always #5 clk = ~clk;

    byte_lane_memory_unit #(.LANES(LANES), .ADDR_WIDTH(AW), .INIT_ZERO(1)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a flat byte array, byte p of an access lives at addr+p.
    task automatic model(input bit st, input logic [1:0] sz, input bit sg, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd, output logic err);
        int n;
        logic [63:0] v;
        n   = 1 << sz;
        err = (n > LANES) || (int'(a) + n - 1 > MEM_BYTES - 1);
        rd  = '0;
        if (n > LANES) return;
        if (st) begin
            if (!err) begin
                for (int p = 0; p < n; p++) mem_m[(int'(a) + p) % MEM_BYTES] = wd[8*(n-1-p) +: 8];
            end
        end else begin
            v = '0;
            for (int p = 0; p < n; p++) v = (v << 8) | 64'(mem_m[(int'(a) + p) % MEM_BYTES]);
            if (sg && v[8*n-1]) v = v | (~64'd0 << (8*n));
            rd = v[DW-1:0];
        end
    endtask

    // Entered and left #1 after a rising edge with the unit idle.
    task automatic do_req(input bit st, input logic [1:0] sz, input bit sg, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int hold,
                          output logic [DW-1:0] got, output logic got_err);
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [DW-1:0] held;
        int            lat;
        model(st, sz, sg, a, wd, exp_rd, exp_err);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr  = a;    req_wdata = wd;
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = AW'($urandom);
        req_wdata  = DW'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);
        check("latency", 64'(lat), st ? 64'd1 : 64'd2);
        check("rdata", 64'(resp_rdata), 64'(exp_rd));
        check("error", 64'(resp_error), 64'(exp_err));
        held    = resp_rdata;
        got     = resp_rdata;
        got_err = resp_error;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", 64'(resp_rdata), 64'(held));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        txn++;
        $display("txn %0d %s size=%0d signed=%0b addr=%05h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 txn, st ? "ST" : "LD", sz, sg, a, wd, got, got_err, lat);
    endtask

    initial begin
        logic [DW-1:0] got;
        logic          gerr;
        logic [DW-1:0] dummy_rd;
        logic          dummy_err;
        int            sel;
        logic [AW-1:0] ra;
        logic [1:0]    rs;

        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_error", 64'(resp_error), 64'd0);
        check("reset_resp_rdata", 64'(resp_rdata), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Word store / load round trip.
        do_req(1'b1, 2'd2, 1'b0, 18'h00100, 32'h11223344, 0, got, gerr);
        do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, 0, got, gerr);
        check("word_load_0x100", 64'(got), 64'h11223344);

        // Unaligned word load spanning two rows.
        do_req(1'b1, 2'd0, 1'b0, 18'h00104, 32'h00000055, 0, got, gerr);
        do_req(1'b0, 2'd2, 1'b0, 18'h00101, 32'h0, 0, got, gerr);
        check("word_load_0x101", 64'(got), 64'h22334455);

        // Row-crossing half store, then byte loads with sign/zero extension.
        do_req(1'b1, 2'd1, 1'b0, 18'h00103, 32'h0000BEEF, 0, got, gerr);
        do_req(1'b0, 2'd0, 1'b1, 18'h00103, 32'h0, 0, got, gerr);
        check("byte_signed_0x103", 64'(got), 64'hFFFFFFBE);
        do_req(1'b0, 2'd0, 1'b0, 18'h00104, 32'h0, 0, got, gerr);
        check("byte_unsigned_0x104", 64'(got), 64'h000000EF);
        do_req(1'b0, 2'd0, 1'b0, 18'h00102, 32'h0, 0, got, gerr);
        check("neighbour_0x102", 64'(got), 64'h00000033);
        do_req(1'b0, 2'd0, 1'b0, 18'h00105, 32'h0, 0, got, gerr);
        check("neighbour_0x105", 64'(got), 64'h00000000);

        // Back-pressure on a load response.
        do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, 3, got, gerr);
        check("held_load_0x100", 64'(got), 64'h112233BE);

        // Store past the top address and an illegal size.
        do_req(1'b1, 2'd2, 1'b0, 18'h3FFFE, 32'hDEADBEEF, 0, got, gerr);
        check("wrap_store_error", 64'(gerr), 64'd1);
        do_req(1'b0, 2'd0, 1'b0, 18'h3FFFE, 32'h0, 0, got, gerr);
        check("wrap_store_no_write_top", 64'(got), 64'h0);
        do_req(1'b0, 2'd0, 1'b0, 18'h00000, 32'h0, 0, got, gerr);
        check("wrap_store_no_write_row0", 64'(got), 64'h0);
        do_req(1'b0, 2'd3, 1'b1, 18'h00100, 32'h0, 0, got, gerr);
        check("illegal_size_error", 64'(gerr), 64'd1);
        check("illegal_size_rdata", 64'(got), 64'h0);
        do_req(1'b1, 2'd3, 1'b0, 18'h00100, 32'hFFFFFFFF, 0, got, gerr);
        do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, 0, got, gerr);
        check("illegal_store_no_write", 64'(got), 64'h112233BE);

        // Wrapped load returns bytes from row 0 and flags an error.
        do_req(1'b1, 2'd1, 1'b0, 18'h3FFFE, 32'h0000A1B2, 0, got, gerr);
        do_req(1'b1, 2'd1, 1'b0, 18'h00000, 32'h0000C3D4, 0, got, gerr);
        do_req(1'b0, 2'd2, 1'b0, 18'h3FFFE, 32'h0, 0, got, gerr);
        check("wrap_load_rdata", 64'(got), 64'hA1B2C3D4);
        check("wrap_load_error", 64'(gerr), 64'd1);

        // Reset while a load sits in READ.
        do_req(1'b1, 2'd2, 1'b0, 18'h00200, 32'hCAFEF00D, 0, got, gerr);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 18'h00200;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("reset_in_read_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_in_read_no_resp", 64'(resp_valid), 64'd0);
            check("reset_in_read_idle", 64'(req_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 2'd2, 1'b0, 18'h00200, 32'h0, 0, got, gerr);
        check("data_survives_reset", 64'(got), 64'hCAFEF00D);

        // Randomized traffic near the middle and both ends of the address space.
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 5);
            if (sel < 4)       ra = 18'h00100 + AW'($urandom_range(0, 31));
            else if (sel == 4) ra = 18'h3FFF8 + AW'($urandom_range(0, 7));
            else               ra = AW'($urandom_range(0, 7));
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), rs, 1'($urandom), ra, DW'($urandom), $urandom_range(0, 2), got, gerr);
        end
        model(1'b0, 2'd0, 1'b0, '0, '0, dummy_rd, dummy_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_lane_memory_unit.md
BYTE_LANE_MEMORY_UNIT -- requirements
Module: byte_lane_memory_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of byte-wide BRAM banks; legal values 2, 4, 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, meaning byte-address width; the word address is ADDR_WIDTH-log2(LANES) bits.
REQ-003 SHALL have parameter INIT_ZERO, default 1, meaning all banks power up zero-filled.
REQ-004 CLOCK_50  in  1  single clock; all state and bank writes update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  unit can accept a request this cycle.
REQ-008 req_store  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size in bytes: 2^req_size; values with 2^req_size > LANES are illegal.
REQ-010 req_signed  in  1  load result is sign-extended; 0 = zero-extended.
REQ-011 req_addr  in  ADDR_WIDTH  byte address; any alignment.
REQ-012 req_wdata  in  8*LANES  store data, right-justified.
REQ-013 resp_valid  out  1  response present; held until resp_ready.
REQ-014 resp_ready  in  1  consumer accepts response.
REQ-015 resp_rdata  out  8*LANES  load result; 0 for stores.
REQ-016 resp_error  out  1  illegal size, or access wrapped past the top address.

Function
REQ-017 Request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; request fields SHALL be captured at that edge.
REQ-018 States SHALL be IDLE, READ, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE transitions: accepted load -> READ; accepted store -> RESP; otherwise remain in IDLE.
REQ-020 READ SHALL last exactly one cycle (synchronous bank read), then -> RESP.
REQ-021 RESP SHALL assert resp_valid; on resp_ready = 1 -> IDLE; otherwise hold RESP with outputs stable.
REQ-022 Latency, accept edge N: store resp_valid from N+1; load resp_valid from N+2.
REQ-023 Byte mapping: byte address A maps to bank LANES-1-(A mod LANES), row A div LANES.
REQ-024 For n = 2^req_size, logical byte p (0..n-1) SHALL be at address req_addr+p and correspond to wdata/rdata bits [8(n-1-p)+7 : 8(n-1-p)] (big-endian, right-justified).
REQ-025 Each bank SHALL compute its own row: base row, or base row + 1 when its byte lies beyond the end of the base row; banks touched by no logical byte SHALL NOT be written.
REQ-026 Store SHALL write all n bytes in the accept cycle only; bank write enables SHALL be 0 in all other cycles.
REQ-027 Load result SHALL be assembled from the n bytes; bits above 8n SHALL be copies of bit 8n-1 if req_signed = 1, else 0.
REQ-028 Illegal size SHALL produce resp_error = 1, no bank write, and resp_rdata = 0, with normal state sequencing.
REQ-029 Access with req_addr + n - 1 > 2^ADDR_WIDTH - 1 SHALL produce resp_error = 1 and no bank write; a load SHALL return the wrapped bytes read from row 0.
REQ-030 Every sub-word size SHALL be supported at every alignment, including row-crossing.
REQ-031 Loads issued after a store response to the same address SHALL return the newly stored data.

Reset
REQ-032 While reset = 1 at a rising edge: state -> IDLE; resp_valid = 0; resp_error = 0; resp_rdata = 0; req_ready = 0 during that cycle and 1 in the following cycle.
REQ-033 Reset SHALL NOT clear bank contents; a request in flight SHALL be discarded without a response, and no bank write SHALL occur during a reset cycle.

Verification
REQ-034 Use LANES=4, ADDR_WIDTH=18. Word store 0x11223344 at address 0x100, then word load at 0x100 -> rdata 0x11223344; store resp at N+1; load resp at N+2.
REQ-035 Half store 0xBEEF at 0x103 (row-crossing), then load size 0 at 0x103 with signed=1 -> 0xFFFFFFBE; load size 0 at 0x104 with signed=0 -> 0x000000EF; neighbouring bytes 0x102 and 0x105 are unchanged.
REQ-036 Word load at 0x101 after REQ-034 store plus byte 0x55 at 0x104 -> 0x22334455.
REQ-037 Hold resp_ready = 0 for 3 cycles on a load: resp_valid and rdata are stable and req_ready = 0 throughout; request accepted the cycle after the handshake.
REQ-038 Word store at 0x3FFFE -> resp_error = 1, memory unchanged; req_size = 3 -> resp_error = 1, rdata = 0.
REQ-039 Assert reset in the READ state -> no response, IDLE state, and data stored before reset is still readable afterward.
